ddr5_act_timing_guard: RTL and testbench
========================================

DDR5_ACT_TIMING_GUARD -- requirements
Module: ddr5_act_timing_guard

Interface
REQ-001 SHALL have parameter NUM_RANKS, default 2, number of ranks tracked; RANK_W = max(1, clog2(NUM_RANKS)).
REQ-002 SHALL have parameter NUM_BG, default 8, bank groups per rank; BG_W = clog2(NUM_BG).
REQ-003 SHALL have parameter FAW_ACTS, default 4, max ACTs per rank inside one tFAW window.
REQ-004 SHALL have parameter TW, default 8, width of timing config fields.
REQ-005 SHALL have parameter STARVE_W, default 12, wait-counter width.
REQ-006 SHALL have parameter CNT_W, default 32, perf-counter width.
REQ-007 SHALL have ports:
clk  in  1  sole clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
cfg_2n  in  1  1 = 2N command spacing, 0 = 1N
cfg_trrd_s  in  TW  min cycles, ACT to ACT, same rank, different BG
cfg_trrd_l  in  TW  min cycles, ACT to ACT, same rank, same BG
cfg_tfaw  in  TW  four-activate window length, cycles
cfg_starve_thresh  in  STARVE_W  wait cycles before starve_flag; 0 disables
req_valid  in  1  command request present
req_cmd  in  4  NOP=0, ACT=1, RD=2, WR=3, PRE=4, REF=5, MRS=6
req_rank  in  RANK_W  target rank
req_bg  in  BG_W  target bank group
req_ready  out  1  request may issue this cycle; grant = req_valid & req_ready
hazard_rrd_s  out  1  tRRD_S blocks current ACT
hazard_rrd_l  out  1  tRRD_L blocks current ACT
hazard_faw  out  1  tFAW blocks current ACT
hazard_spacing  out  1  2N spacing blocks current command
starve_flag  out  1  current request waited >= threshold
cnt_rrd_stalls  out  CNT_W  cycles stalled by tRRD_S or tRRD_L
cnt_faw_stalls  out  CNT_W  cycles stalled by tFAW
cnt_starve_events  out  CNT_W  requests that reached starvation

Function
REQ-008 SHALL keep, per rank, one tRRD_S down-counter, NUM_BG tRRD_L down-counters and FAW_ACTS tFAW slot down-counters, all TW bits.
REQ-009 On ACT grant at cycle T to rank r, bg g: SHALL load rrd_s[r] with cfg_trrd_s-1 and rrd_l[r][g] with cfg_trrd_l-1; cfg value 0 or 1 loads 0.
REQ-010 On same grant SHALL load lowest-index zero tFAW slot of rank r with cfg_tfaw-1 (0 if cfg_tfaw <= 1).
REQ-011 Every nonzero counter SHALL decrement by 1 each cycle it is not being loaded; zero holds.
REQ-012 hazard_rrd_s SHALL = req_valid & ACT & rrd_s[req_rank] != 0; hazard_rrd_l SHALL = req_valid & ACT & rrd_l[req_rank][req_bg] != 0; both may assert together.
REQ-013 hazard_faw SHALL = req_valid & ACT & all FAW_ACTS slots of req_rank nonzero.
REQ-014 Timing SHALL be per rank only; an ACT to rank r never affects rank s != r.
REQ-015 Net effect: next ACT same rank other BG legal at >= T+cfg_trrd_s; same BG at >= T+max(cfg_trrd_s,cfg_trrd_l); (FAW_ACTS+1)th ACT legal at >= T1+cfg_tfaw, T1 = oldest in-window ACT.
REQ-016 Spacing: with cfg_2n=1, after any non-NOP grant at T, hazard_spacing SHALL assert for non-NOP requests in cycle T+1 only; cfg_2n=0 never asserts it; spacing spans all ranks.
REQ-017 req_ready SHALL = !(hazard_rrd_s | hazard_rrd_l | hazard_faw | hazard_spacing); combinational, no dependence on req_valid beyond hazards; NOP always ready and updates no state.
REQ-018 Starvation SHALL never override timing; it is reporting only.
REQ-019 Wait counter SHALL increment (saturating) each cycle req_valid & !req_ready; clear on grant or !req_valid.
REQ-020 starve_flag SHALL = cfg_starve_thresh != 0 & wait >= cfg_starve_thresh (registered-counter compare).
REQ-021 cnt_starve_events SHALL increment on 0->1 transition of starve_flag.
REQ-022 cnt_rrd_stalls SHALL increment on req_valid & (hazard_rrd_s | hazard_rrd_l); cnt_faw_stalls on req_valid & hazard_faw; all perf counters saturate at all-ones.
REQ-023 cfg changes SHALL affect only subsequent loads; in-flight counters run out unchanged.
REQ-024 Simultaneous ACT grant and slot expiry: expiry decrement and new load SHALL both apply in that cycle; the new ACT may use a slot reaching zero only next cycle.

Reset
REQ-025 While rst=1 SHALL zero all timing counters, wait counter, spacing state and perf counters; outputs: hazards 0, starve_flag 0, counters 0, req_ready 1 for any request.
REQ-026 rst asserted mid-operation SHALL discard all pending windows; first cycle after release accepts any command.

Verification
REQ-027 cfg_trrd_s=4, cfg_trrd_l=6: ACT r0 bg0 at T=0; ACT r0 bg1 held -> ready at T=4; ACT r0 bg0 -> ready at T=6; hazard_rrd_l high T=1..5.
REQ-028 cfg_tfaw=16, trrd=1: ACTs r0 at T=0,1,2,3; fifth ACT r0 stalls, ready at T=16; cnt_faw_stalls=12; concurrent ACT r1 at T=4 granted.
REQ-029 cfg_2n=1: RD granted at T=0, WR offered T=1 -> hazard_spacing=1, granted T=2; NOP at T=1 ready; cfg_2n=0 -> WR granted T=1.
REQ-030 cfg_starve_thresh=10, request blocked 20 cycles -> starve_flag rises after 10th stalled cycle, cnt_starve_events=1, request still not granted until hazard clears.
REQ-031 Start tFAW window, assert rst one cycle at T=5 -> after release, ACT r0 granted immediately; all counters 0.
REQ-032 TW=8, cfg_tfaw=255, CNT_W=4 force 20 stalls -> slot counts 254..0 without wrap; cnt_faw_stalls saturates at 15.

Source files
------------

// File: rtl/ddr5_act_timing_guard_if.sv
// Command request channel between a DDR5 command scheduler and the ACT timing guard.
//
// Signals:
//   req_valid  scheduler has a command to issue this cycle
//   req_cmd    command code: NOP=0, ACT=1, RD=2, WR=3, PRE=4, REF=5, MRS=6
//   req_rank   target rank
//   req_bg     target bank group
//   req_ready  guard allows the command to issue; grant = req_valid & req_ready
//
// Modports:
//   master  scheduler side (drives the request, observes ready)
//   slave   guard side (observes the request, drives ready)

interface ddr5_act_timing_guard_if #(
    parameter int unsigned NUM_RANKS = 2,
    parameter int unsigned NUM_BG    = 8
);
    localparam int unsigned RANK_W = (NUM_RANKS > 1) ? $clog2(NUM_RANKS) : 1;
    localparam int unsigned BG_W   = (NUM_BG > 1) ? $clog2(NUM_BG) : 1;

    logic              req_valid;
    logic [3:0]        req_cmd;
    logic [RANK_W-1:0] req_rank;
    logic [BG_W-1:0]   req_bg;
    logic              req_ready;

    modport master (
        output req_valid,
        output req_cmd,
        output req_rank,
        output req_bg,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_cmd,
        input  req_rank,
        input  req_bg,
        output req_ready
    );
endinterface

// File: rtl/ddr5_act_timing_guard.sv
// DDR5 activate timing guard. Tracks tRRD_S, tRRD_L and tFAW per rank plus 1N/2N
// command spacing, and gates the scheduler's request channel with req_ready. Also
// reports request starvation and keeps saturating stall/starvation counters.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   cfg_2n              1 = 2N command spacing, 0 = 1N
//   cfg_trrd_s/_l       minimum ACT-to-ACT spacing, different / same bank group
//   cfg_tfaw            four-activate window length
//   cfg_starve_thresh   wait cycles before starve_flag (0 disables)
//   req                 request channel (slave side)
//   hazard_*            which timing rule blocks the current request
//   starve_flag         current request has waited >= threshold
//   cnt_*               saturating performance counters

module ddr5_act_timing_guard #(
    parameter int unsigned NUM_RANKS = 2,
    parameter int unsigned NUM_BG    = 8,
    parameter int unsigned FAW_ACTS  = 4,
    parameter int unsigned TW        = 8,
    parameter int unsigned STARVE_W  = 12,
    parameter int unsigned CNT_W     = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_2n,
    input  logic [TW-1:0]       cfg_trrd_s,
    input  logic [TW-1:0]       cfg_trrd_l,
    input  logic [TW-1:0]       cfg_tfaw,
    input  logic [STARVE_W-1:0] cfg_starve_thresh,
    ddr5_act_timing_guard_if.slave req,
    output logic                hazard_rrd_s,
    output logic                hazard_rrd_l,
    output logic                hazard_faw,
    output logic                hazard_spacing,
    output logic                starve_flag,
    output logic [CNT_W-1:0]    cnt_rrd_stalls,
    output logic [CNT_W-1:0]    cnt_faw_stalls,
    output logic [CNT_W-1:0]    cnt_starve_events
);

    localparam logic [3:0] CmdNop = 4'd0;
    localparam logic [3:0] CmdAct = 4'd1;

    logic [TW-1:0] rrd_s_q [NUM_RANKS];
    logic [TW-1:0] rrd_s_d [NUM_RANKS];
    logic [TW-1:0] rrd_l_q [NUM_RANKS][NUM_BG];
    logic [TW-1:0] rrd_l_d [NUM_RANKS][NUM_BG];
    logic [TW-1:0] faw_q   [NUM_RANKS][FAW_ACTS];
    logic [TW-1:0] faw_d   [NUM_RANKS][FAW_ACTS];

    logic                spacing_q, spacing_d;
    logic [STARVE_W-1:0] wait_q, wait_d;
    logic                starve_q;
    logic [CNT_W-1:0]    cnt_rrd_q, cnt_rrd_d;
    logic [CNT_W-1:0]    cnt_faw_q, cnt_faw_d;
    logic [CNT_W-1:0]    cnt_starve_q, cnt_starve_d;

    logic is_act, faw_full, ready, grant, act_grant, slot_taken;

    // A programmed spacing of N cycles is held off for N-1 cycles after the grant cycle.
    function automatic logic [TW-1:0] load_val(input logic [TW-1:0] v);
        return (v <= TW'(1)) ? '0 : v - TW'(1);
    endfunction

    function automatic logic [TW-1:0] dec(input logic [TW-1:0] v);
        return (v == '0) ? '0 : v - TW'(1);
    endfunction

    // Hazards and ready. Gated by rst so the guard is transparent while in reset.
    always_comb begin
        is_act   = req.req_valid && (req.req_cmd == CmdAct);
        faw_full = 1'b1;
        for (int k = 0; k < FAW_ACTS; k++) begin
            if (faw_q[req.req_rank][k] == '0) faw_full = 1'b0;
        end
        hazard_rrd_s   = !rst && is_act && (rrd_s_q[req.req_rank] != '0);
        hazard_rrd_l   = !rst && is_act && (rrd_l_q[req.req_rank][req.req_bg] != '0);
        hazard_faw     = !rst && is_act && faw_full;
        hazard_spacing = !rst && cfg_2n && spacing_q && req.req_valid &&
                         (req.req_cmd != CmdNop);
        ready     = !(hazard_rrd_s || hazard_rrd_l || hazard_faw || hazard_spacing);
        grant     = req.req_valid && ready;
        act_grant = grant && (req.req_cmd == CmdAct);
        starve_flag = !rst && (cfg_starve_thresh != '0) && (wait_q >= cfg_starve_thresh);
    end

    assign req.req_ready = ready;

    // Timing counters: free-running decrement, overridden by loads on an ACT grant.
    // The tFAW slot is chosen from registered values, so a slot expiring this cycle
    // is not reused until the next one.
    always_comb begin
        slot_taken = 1'b0;
        for (int r = 0; r < NUM_RANKS; r++) begin
            rrd_s_d[r] = dec(rrd_s_q[r]);
            for (int g = 0; g < NUM_BG; g++) begin
                rrd_l_d[r][g] = dec(rrd_l_q[r][g]);
            end
            for (int k = 0; k < FAW_ACTS; k++) begin
                faw_d[r][k] = dec(faw_q[r][k]);
            end
        end
        if (act_grant) begin
            rrd_s_d[req.req_rank]             = load_val(cfg_trrd_s);
            rrd_l_d[req.req_rank][req.req_bg] = load_val(cfg_trrd_l);
            for (int k = 0; k < FAW_ACTS; k++) begin
                if (!slot_taken && (faw_q[req.req_rank][k] == '0)) begin
                    faw_d[req.req_rank][k] = load_val(cfg_tfaw);
                    slot_taken = 1'b1;
                end
            end
        end
    end

    // Spacing, starvation tracking and perf counters.
    always_comb begin
        spacing_d = cfg_2n && grant && (req.req_cmd != CmdNop);

        wait_d = '0;
        if (req.req_valid && !ready) begin
            wait_d = (wait_q == '1) ? wait_q : wait_q + STARVE_W'(1);
        end

        cnt_rrd_d = cnt_rrd_q;
        if ((hazard_rrd_s || hazard_rrd_l) && (cnt_rrd_q != '1)) begin
            cnt_rrd_d = cnt_rrd_q + CNT_W'(1);
        end
        cnt_faw_d = cnt_faw_q;
        if (hazard_faw && (cnt_faw_q != '1)) begin
            cnt_faw_d = cnt_faw_q + CNT_W'(1);
        end
        cnt_starve_d = cnt_starve_q;
        if (starve_flag && !starve_q && (cnt_starve_q != '1)) begin
            cnt_starve_d = cnt_starve_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_RANKS; r++) begin
                rrd_s_q[r] <= '0;
                for (int g = 0; g < NUM_BG; g++) begin
                    rrd_l_q[r][g] <= '0;
                end
                for (int k = 0; k < FAW_ACTS; k++) begin
                    faw_q[r][k] <= '0;
                end
            end
            spacing_q    <= 1'b0;
            wait_q       <= '0;
            starve_q     <= 1'b0;
            cnt_rrd_q    <= '0;
            cnt_faw_q    <= '0;
            cnt_starve_q <= '0;
        end else begin
            rrd_s_q      <= rrd_s_d;
            rrd_l_q      <= rrd_l_d;
            faw_q        <= faw_d;
            spacing_q    <= spacing_d;
            wait_q       <= wait_d;
            starve_q     <= starve_flag;
            cnt_rrd_q    <= cnt_rrd_d;
            cnt_faw_q    <= cnt_faw_d;
            cnt_starve_q <= cnt_starve_d;
        end
    end

    // Counters read as zero for the whole reset interval, including its first cycle.
    assign cnt_rrd_stalls    = rst ? '0 : cnt_rrd_q;
    assign cnt_faw_stalls    = rst ? '0 : cnt_faw_q;
    assign cnt_starve_events = rst ? '0 : cnt_starve_q;

endmodule

// File: tb/tb_ddr5_act_timing_guard.sv
// Directed testbench for ddr5_act_timing_guard. A default-parameter instance covers
// tRRD, tFAW, spacing, starvation and reset; a CNT_W=4 instance covers a long tFAW
// window with counter saturation.

module tb_ddr5_act_timing_guard;

    localparam logic [3:0] NOP = 4'd0;
    localparam logic [3:0] ACT = 4'd1;
    localparam logic [3:0] RD  = 4'd2;
    localparam logic [3:0] WR  = 4'd3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_2n = 1'b0;
    logic [7:0]  cfg_trrd_s = 8'd1;
    logic [7:0]  cfg_trrd_l = 8'd1;
    logic [7:0]  cfg_tfaw = 8'd0;
    logic [11:0] cfg_starve_thresh = 12'd0;

    logic        hz_s, hz_l, hz_faw, hz_sp, starve;
    logic [31:0] cnt_rrd, cnt_faw, cnt_st;
    logic        s_hz_s, s_hz_l, s_hz_faw, s_hz_sp, s_starve;
    logic [3:0]  s_cnt_rrd, s_cnt_faw, s_cnt_st;

    int checks = 0;
    int errors = 0;

    ddr5_act_timing_guard_if #(.NUM_RANKS(2), .NUM_BG(8)) bus ();
    ddr5_act_timing_guard_if #(.NUM_RANKS(2), .NUM_BG(8)) bus2 ();

    ddr5_act_timing_guard dut (
        .clk(clk), .rst(rst), .cfg_2n(cfg_2n), .cfg_trrd_s(cfg_trrd_s),
        .cfg_trrd_l(cfg_trrd_l), .cfg_tfaw(cfg_tfaw), .cfg_starve_thresh(cfg_starve_thresh),
        .req(bus), .hazard_rrd_s(hz_s), .hazard_rrd_l(hz_l), .hazard_faw(hz_faw),
        .hazard_spacing(hz_sp), .starve_flag(starve), .cnt_rrd_stalls(cnt_rrd),
        .cnt_faw_stalls(cnt_faw), .cnt_starve_events(cnt_st)
    );

    ddr5_act_timing_guard #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .cfg_2n(cfg_2n), .cfg_trrd_s(cfg_trrd_s),
        .cfg_trrd_l(cfg_trrd_l), .cfg_tfaw(cfg_tfaw), .cfg_starve_thresh(cfg_starve_thresh),
        .req(bus2), .hazard_rrd_s(s_hz_s), .hazard_rrd_l(s_hz_l), .hazard_faw(s_hz_faw),
        .hazard_spacing(s_hz_sp), .starve_flag(s_starve), .cnt_rrd_stalls(s_cnt_rrd),
        .cnt_faw_stalls(s_cnt_faw), .cnt_starve_events(s_cnt_st)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] c, input logic r,
                         input logic [2:0] g);
        bus.req_valid = v;
        bus.req_cmd   = c;
        bus.req_rank  = r;
        bus.req_bg    = g;
        #1;
    endtask

    task automatic drive2(input logic v, input logic [3:0] c, input logic r,
                          input logic [2:0] g);
        bus2.req_valid = v;
        bus2.req_cmd   = c;
        bus2.req_rank  = r;
        bus2.req_bg    = g;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, NOP, 1'b0, 3'd0);
        drive2(1'b0, NOP, 1'b0, 3'd0);
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive2(1'b0, NOP, 1'b0, 3'd0);
        drive(1'b1, ACT, 1'b0, 3'd0);
        checks++;
        if ({bus.req_ready, hz_s, hz_l, hz_faw, hz_sp, starve} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 100000",
                     {bus.req_ready, hz_s, hz_l, hz_faw, hz_sp, starve});
        end
        next_cycle();
        next_cycle();
        rst = 1'b0;
        drive(1'b0, NOP, 1'b0, 3'd0);
        checks++;
        if ({cnt_rrd, cnt_faw, cnt_st} !== 96'd0 || starve !== 1'b0) begin
            errors++;
            $display("FAIL reset_counters: got %0h/%0h/%0h starve %b expected 0",
                     cnt_rrd, cnt_faw, cnt_st, starve);
        end
        drive(1'b1, ACT, 1'b1, 3'd7);
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_act: ready got %b expected 1", bus.req_ready);
        end
        next_cycle();
    endtask

    task automatic test_rrd_s();
        cfg_trrd_s = 8'd4;
        cfg_trrd_l = 8'd6;
        cfg_tfaw   = 8'd0;
        do_reset();
        drive(1'b1, ACT, 1'b0, 3'd0);
        next_cycle();
        for (int t = 1; t <= 4; t++) begin
            drive(1'b1, ACT, 1'b0, 3'd1);
            checks++;
            if (bus.req_ready !== (t >= 4) || hz_s !== (t < 4) || hz_l !== 1'b0) begin
                errors++;
                $display("FAIL rrd_s_t%0d: ready/hz_s/hz_l got %b%b%b expected %b%b0",
                         t, bus.req_ready, hz_s, hz_l, t >= 4, t < 4);
            end
            next_cycle();
        end
        drive(1'b0, NOP, 1'b0, 3'd0);
        checks++;
        if (cnt_rrd !== 32'd3) begin
            errors++;
            $display("FAIL rrd_s_count: got %0d expected 3", cnt_rrd);
        end
    endtask

    task automatic test_rrd_l();
        cfg_trrd_s = 8'd4;
        cfg_trrd_l = 8'd6;
        do_reset();
        drive(1'b1, ACT, 1'b0, 3'd0);
        next_cycle();
        // New tRRD_L only applies to the next load; the running window keeps 6.
        cfg_trrd_l = 8'd2;
        for (int t = 1; t <= 6; t++) begin
            drive(1'b1, ACT, 1'b0, 3'd0);
            checks++;
            if (hz_l !== (t <= 5) || bus.req_ready !== (t == 6) || hz_s !== (t < 4)) begin
                errors++;
                $display("FAIL rrd_l_t%0d: hz_l/ready/hz_s got %b%b%b expected %b%b%b",
                         t, hz_l, bus.req_ready, hz_s, t <= 5, t == 6, t < 4);
            end
            next_cycle();
        end
        for (int t = 7; t <= 8; t++) begin
            drive(1'b1, ACT, 1'b0, 3'd0);
            checks++;
            if (hz_l !== (t == 7)) begin
                errors++;
                $display("FAIL rrd_l_newcfg_t%0d: got %b expected %b", t, hz_l, t == 7);
            end
            next_cycle();
        end
        drive(1'b0, NOP, 1'b0, 3'd0);
        checks++;
        if (cnt_rrd !== 32'd7) begin
            errors++;
            $display("FAIL rrd_l_count: got %0d expected 7", cnt_rrd);
        end
    endtask

    task automatic test_faw();
        cfg_trrd_s = 8'd1;
        cfg_trrd_l = 8'd1;
        cfg_tfaw   = 8'd16;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, ACT, 1'b0, 3'(i));
            checks++;
            if (bus.req_ready !== 1'b1) begin
                errors++;
                $display("FAIL faw_fill_%0d: ready got %b expected 1", i, bus.req_ready);
            end
            next_cycle();
        end
        for (int t = 4; t <= 16; t++) begin
            drive(1'b1, ACT, 1'b0, 3'd4);
            checks++;
            if (hz_faw !== (t < 16) || bus.req_ready !== (t == 16)) begin
                errors++;
                $display("FAIL faw_t%0d: hz_faw/ready got %b%b expected %b%b",
                         t, hz_faw, bus.req_ready, t < 16, t == 16);
            end
            next_cycle();
        end
        drive(1'b0, NOP, 1'b0, 3'd0);
        checks++;
        if (cnt_faw !== 32'd12 || cnt_rrd !== 32'd0) begin
            errors++;
            $display("FAIL faw_count: faw/rrd got %0d/%0d expected 12/0", cnt_faw, cnt_rrd);
        end
        // Full window on rank 0 must not block rank 1.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, ACT, 1'b0, 3'(i));
            next_cycle();
        end
        drive(1'b1, ACT, 1'b1, 3'd0);
        checks++;
        if (bus.req_ready !== 1'b1 || hz_faw !== 1'b0) begin
            errors++;
            $display("FAIL faw_other_rank: ready/hz_faw got %b%b expected 10",
                     bus.req_ready, hz_faw);
        end
        next_cycle();
        drive(1'b1, ACT, 1'b0, 3'd5);
        checks++;
        if (hz_faw !== 1'b1) begin
            errors++;
            $display("FAIL faw_rank0_still_full: got %b expected 1", hz_faw);
        end
        next_cycle();
        drive(1'b0, NOP, 1'b0, 3'd0);
    endtask

    task automatic test_spacing();
        cfg_trrd_s = 8'd1;
        cfg_trrd_l = 8'd1;
        cfg_tfaw   = 8'd0;
        cfg_2n     = 1'b1;
        do_reset();
        drive(1'b1, RD, 1'b0, 3'd0);
        next_cycle();
        drive(1'b1, WR, 1'b1, 3'd0);
        checks++;
        if (hz_sp !== 1'b1 || bus.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL spacing_block: hz_sp/ready got %b%b expected 10", hz_sp, bus.req_ready);
        end
        next_cycle();
        drive(1'b1, WR, 1'b1, 3'd0);
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL spacing_release: ready got %b expected 1", bus.req_ready);
        end
        next_cycle();
        drive(1'b1, NOP, 1'b0, 3'd0);
        checks++;
        if (bus.req_ready !== 1'b1 || hz_sp !== 1'b0) begin
            errors++;
            $display("FAIL spacing_nop: ready/hz_sp got %b%b expected 10", bus.req_ready, hz_sp);
        end
        next_cycle();
        drive(1'b1, RD, 1'b0, 3'd0);
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL spacing_after_nop: ready got %b expected 1", bus.req_ready);
        end
        next_cycle();
        cfg_2n = 1'b0;
        drive(1'b0, NOP, 1'b0, 3'd0);
        next_cycle();
        drive(1'b1, RD, 1'b0, 3'd0);
        next_cycle();
        drive(1'b1, WR, 1'b0, 3'd0);
        checks++;
        if (bus.req_ready !== 1'b1 || hz_sp !== 1'b0) begin
            errors++;
            $display("FAIL spacing_1n: ready/hz_sp got %b%b expected 10", bus.req_ready, hz_sp);
        end
        next_cycle();
        drive(1'b0, NOP, 1'b0, 3'd0);
    endtask

    task automatic test_starve();
        cfg_trrd_s        = 8'd1;
        cfg_trrd_l        = 8'd21;
        cfg_tfaw          = 8'd0;
        cfg_starve_thresh = 12'd10;
        do_reset();
        drive(1'b1, ACT, 1'b0, 3'd2);
        next_cycle();
        for (int t = 1; t <= 21; t++) begin
            drive(1'b1, ACT, 1'b0, 3'd2);
            checks++;
            if (starve !== (t >= 11) || bus.req_ready !== (t == 21)) begin
                errors++;
                $display("FAIL starve_t%0d: starve/ready got %b%b expected %b%b",
                         t, starve, bus.req_ready, t >= 11, t == 21);
            end
            if (t == 12) begin
                checks++;
                if (cnt_st !== 32'd1) begin
                    errors++;
                    $display("FAIL starve_event: got %0d expected 1", cnt_st);
                end
            end
            next_cycle();
        end
        drive(1'b0, NOP, 1'b0, 3'd0);
        checks++;
        if (starve !== 1'b0 || cnt_st !== 32'd1 || cnt_rrd !== 32'd20) begin
            errors++;
            $display("FAIL starve_end: starve/events/rrd got %b/%0d/%0d expected 0/1/20",
                     starve, cnt_st, cnt_rrd);
        end
        cfg_starve_thresh = 12'd0;
        cfg_trrd_l        = 8'd1;
    endtask

    task automatic test_reset_mid();
        cfg_trrd_s = 8'd1;
        cfg_trrd_l = 8'd1;
        cfg_tfaw   = 8'd16;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, ACT, 1'b0, 3'(i));
            next_cycle();
        end
        drive(1'b1, ACT, 1'b0, 3'd4);
        next_cycle();
        rst = 1'b1;
        drive(1'b1, ACT, 1'b0, 3'd4);
        checks++;
        if (bus.req_ready !== 1'b1 || hz_faw !== 1'b0 || cnt_faw !== 32'd0) begin
            errors++;
            $display("FAIL midrst_during: ready/hz_faw/cnt got %b%b/%0d expected 10/0",
                     bus.req_ready, hz_faw, cnt_faw);
        end
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, ACT, 1'b0, 3'(i));
            checks++;
            if (bus.req_ready !== 1'b1 || cnt_faw !== 32'd0) begin
                errors++;
                $display("FAIL midrst_act_%0d: ready/cnt got %b/%0d expected 1/0",
                         i, bus.req_ready, cnt_faw);
            end
            next_cycle();
        end
        drive(1'b1, ACT, 1'b0, 3'd4);
        checks++;
        if (hz_faw !== 1'b1) begin
            errors++;
            $display("FAIL midrst_new_window: hz_faw got %b expected 1", hz_faw);
        end
        next_cycle();
        drive(1'b0, NOP, 1'b0, 3'd0);
    endtask

    task automatic test_saturate();
        int bad;
        cfg_trrd_s = 8'd1;
        cfg_trrd_l = 8'd1;
        cfg_tfaw   = 8'd255;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive2(1'b1, ACT, 1'b0, 3'(i));
            next_cycle();
        end
        bad = 0;
        for (int t = 4; t <= 255; t++) begin
            drive2(1'b1, ACT, 1'b0, 3'd4);
            if (s_hz_faw !== (t < 255) || bus2.req_ready !== (t == 255)) bad++;
            if (t == 18) begin
                checks++;
                if (s_cnt_faw !== 4'd14) begin
                    errors++;
                    $display("FAIL sat_count14: got %0d expected 14", s_cnt_faw);
                end
            end
            if (t == 24) begin
                checks++;
                if (s_cnt_faw !== 4'd15) begin
                    errors++;
                    $display("FAIL sat_count20: got %0d expected 15", s_cnt_faw);
                end
            end
            next_cycle();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL sat_window: %0d cycles wrong expected 0 (ready only at 255)", bad);
        end
        drive2(1'b0, NOP, 1'b0, 3'd0);
        checks++;
        if (s_cnt_faw !== 4'd15) begin
            errors++;
            $display("FAIL sat_final: got %0d expected 15", s_cnt_faw);
        end
    endtask

    initial begin
        test_reset();
        test_rrd_s();
        test_rrd_l();
        test_faw();
        test_spacing();
        test_starve();
        test_reset_mid();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
